// File: rtl/adc_scan_sequencer_if.sv
// rtl/adc_scan_sequencer_if.sv - CPU peripheral bus bundle for the ADC scan sequencer
//
// Signals:
//   valid  master -> slave  bus request, held until ready is seen
//   ready  slave -> master  one-cycle acknowledge
//   addr   master -> slave  byte address
//   wstrb  master -> slave  byte-lane write strobes, 0 = read
//   wdata  master -> slave  write data
//   rdata  slave -> master  read data, valid while ready=1
interface adc_scan_sequencer_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, output addr, output wstrb, output wdata,
                    input ready, input rdata);
    modport slave  (input valid, input addr, input wstrb, input wdata,
                    output ready, output rdata);
endinterface

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - bus-mapped MCP3008 conversion scheduler driving a byte-wide SPI engine
//
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   bus        CPU register bus (slave side)
//   spi_start  one-cycle pulse starting one byte transfer
//   spi_tx     byte to send, held from spi_start until spi_done
//   spi_done   one-cycle pulse when the engine finishes a byte
//   spi_rx     received byte, valid with spi_done
//   cs_n       ADC chip select, active low
//
// Registers (addr[5:2]): 0 CTRL {MASK[15:8], GO[1], EN[0]}, 1 STATUS {CUR[10:8], DONE[1], BUSY[0]},
// 2 GAP[15:0], 8+n RES[n] {FRESH[31], result[9:0]}.
module adc_scan_sequencer #(
    parameter int NCH = 8
) (
    input  logic                clk,
    input  logic                resetn,
    adc_scan_sequencer_if.slave bus,
    output logic                spi_start,
    output logic [7:0]          spi_tx,
    input  logic                spi_done,
    input  logic [7:0]          spi_rx,
    output logic                cs_n
);

    // Channels at or above NCH can never be enabled, so the mask register never holds them.
    localparam logic [7:0] NCH_MASK = 8'((16'd1 << NCH) - 16'd1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_BYTE0, S_BYTE1, S_BYTE2, S_STORE, S_GAP
    } state_t;

    state_t      state;
    logic        en;
    logic        go_req;
    logic        cont;      // current scan was launched in continuous mode
    logic [7:0]  mask;
    logic [15:0] gap_cfg;
    logic [15:0] gap_cnt;
    logic        done;
    logic [2:0]  cur;
    logic [1:0]  rx1;
    logic [7:0]  rx2;
    logic [9:0]  res_val [8];
    logic [7:0]  res_fresh;
    logic        hold;      // request already acknowledged; wait for valid to drop

    // Returns {found, index} of the lowest set bit of m at or above start.
    function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] start);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (4'(i) >= start)) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    logic        acc;
    logic        wr;
    logic [3:0]  reg_idx;
    logic [15:0] gap_eff;
    logic [3:0]  first_any;
    logic [3:0]  next_up;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign acc       = bus.valid && !hold;
    assign wr        = |bus.wstrb;
    assign reg_idx   = bus.addr[5:2];
    assign gap_eff   = (gap_cfg == 16'd0) ? 16'd1 : gap_cfg;
    assign first_any = find_from(mask, 4'd0);
    assign next_up   = find_from(mask, {1'b0, cur} + 4'd1);
    assign unused_bits = ^{bus.addr[31:6], bus.addr[1:0], bus.wdata[31:16]};

    always_comb begin
        rd_val = 32'd0;
        case (reg_idx)
            4'd0:    rd_val = {16'd0, mask, 7'd0, en};
            4'd1:    rd_val = {21'd0, cur, 6'd0, done, (state != S_IDLE)};
            4'd2:    rd_val = {16'd0, gap_cfg};
            default: begin
                if (reg_idx[3]) begin
                    rd_val = {res_fresh[reg_idx[2:0]], 21'd0, res_val[reg_idx[2:0]]};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            en        <= 1'b0;
            go_req    <= 1'b0;
            cont      <= 1'b0;
            mask      <= 8'd0;
            gap_cfg   <= 16'd0;
            gap_cnt   <= 16'd0;
            done      <= 1'b0;
            cur       <= 3'd0;
            rx1       <= 2'd0;
            rx2       <= 8'd0;
            res_fresh <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                res_val[i] <= 10'd0;
            end
            hold      <= 1'b0;
            bus.ready <= 1'b0;
            bus.rdata <= 32'd0;
            spi_start <= 1'b0;
            spi_tx    <= 8'd0;
            cs_n      <= 1'b1;
        end else begin
            bus.ready <= 1'b0;
            bus.rdata <= 32'd0;
            spi_start <= 1'b0;
            go_req    <= 1'b0;

            if (!bus.valid) begin
                hold <= 1'b0;
            end

            // Bus access lands on the same edge that raises ready; the FSM updates below
            // come later in this block so a coincident STORE or DONE set wins.
            if (acc) begin
                hold      <= 1'b1;
                bus.ready <= 1'b1;
                bus.rdata <= rd_val;
                if (wr) begin
                    case (reg_idx)
                        4'd0: begin
                            if (bus.wstrb[0]) begin
                                en     <= bus.wdata[0];
                                go_req <= bus.wdata[1] && (state == S_IDLE);
                            end
                            if (bus.wstrb[1]) begin
                                mask <= bus.wdata[15:8] & NCH_MASK;
                            end
                        end
                        4'd1: begin
                            if (bus.wstrb[0] && bus.wdata[1]) begin
                                done <= 1'b0;
                            end
                        end
                        4'd2: begin
                            if (bus.wstrb[0]) gap_cfg[7:0]  <= bus.wdata[7:0];
                            if (bus.wstrb[1]) gap_cfg[15:8] <= bus.wdata[15:8];
                        end
                        default: ;
                    endcase
                end else if (reg_idx[3]) begin
                    res_fresh[reg_idx[2:0]] <= 1'b0;
                end
            end

            case (state)
                S_IDLE: begin
                    if ((en || go_req) && first_any[3]) begin
                        cur   <= first_any[2:0];
                        cont  <= en;
                        cs_n  <= 1'b0;
                        state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    spi_start <= 1'b1;
                    spi_tx    <= 8'h01;
                    state     <= S_BYTE0;
                end
                S_BYTE0: begin
                    if (spi_done) begin
                        spi_start <= 1'b1;
                        spi_tx    <= {1'b1, cur, 4'b0000};
                        state     <= S_BYTE1;
                    end
                end
                S_BYTE1: begin
                    if (spi_done) begin
                        rx1       <= spi_rx[1:0];
                        spi_start <= 1'b1;
                        spi_tx    <= 8'h00;
                        state     <= S_BYTE2;
                    end
                end
                S_BYTE2: begin
                    if (spi_done) begin
                        rx2   <= spi_rx;
                        cs_n  <= 1'b1;
                        state <= S_STORE;
                    end
                end
                S_STORE: begin
                    res_val[cur]   <= {rx1, rx2};
                    res_fresh[cur] <= 1'b1;
                    gap_cnt        <= 16'd1;
                    state          <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt >= gap_eff) begin
                        if (cont && !en) begin
                            // Continuous scan stopped mid-way: not a completed scan.
                            state <= S_IDLE;
                        end else if (next_up[3]) begin
                            cur   <= next_up[2:0];
                            cs_n  <= 1'b0;
                            state <= S_SELECT;
                        end else begin
                            done <= 1'b1;
                            if (en && first_any[3]) begin
                                cur   <= first_any[2:0];
                                cont  <= 1'b1;
                                cs_n  <= 1'b0;
                                state <= S_SELECT;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
